fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage of the RISC-V core. Holds the PC, issues one instruction-memory request at a time, and buffers returned words in a small prefetch FIFO. Presents each instruction to decode with its PC, an immediate-select code, and a pre-extracted raw immediate, which are the `SEL`/`Dato` inputs of the downstream immediate-format mux. Handles branch/jump redirects by flushing the FIFO and discarding any in-flight response.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset.
- `DEPTH`, default 2: prefetch FIFO entries; must be ≥1.
- `clk`  in  1  single clock; all logic is on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `imem_req`  out  1  one-cycle request pulse.
- `imem_addr`  out  32  request address; valid when `imem_req`=1.
- `imem_ack`  in  1  one-cycle response strobe; earliest 1 cycle after `imem_req`.
- `imem_rdata`  in  32  instruction word; valid when `imem_ack`=1.
- `redirect`  in  1  flush and restart fetch at `redirect_pc`.
- `redirect_pc`  in  32  new PC; must be word-aligned.
- `out_valid`  out  1  FIFO head valid.
- `out_ready`  in  1  decode accepts the head.
- `out_instr`  out  32  head instruction.
- `out_pc`  out  32  head PC.
- `out_imm_sel`  out  2  00 = zero-extended low half, 01 = upper half (LUI), 10 = no immediate; 11 is never driven.
- `out_imm_raw`  out  32  raw immediate handed to the immediate mux.

## Operation
- FSM states:
  - IDLE: if FIFO count < DEPTH and no `redirect`, pulse `imem_req` with `imem_addr`=pc, then go to WAIT.
  - WAIT: on `imem_ack`, push {rdata, pc}, set pc += 4, return to IDLE.
  - DISCARD: wait for `imem_ack`, drop the data, return to IDLE.
- Redirect while in IDLE: pc ← `redirect_pc`, flush FIFO, stay in IDLE, no request issued that cycle.
- Redirect while in WAIT without ack: pc ← `redirect_pc`, flush, go to DISCARD.
- Redirect while in WAIT with ack in the same cycle: the acked data is dropped, pc ← `redirect_pc`, flush, go to IDLE.
- Redirect while in DISCARD: pc ← `redirect_pc`, stay in DISCARD (or go to IDLE if ack arrives the same cycle).
- Pop occurs when `out_valid` and `out_ready` are both high. A pop in the same cycle as a redirect is honoured, and the flush then empties the FIFO.
- A request is only issued when count < DEPTH, and count cannot grow while in WAIT. A push therefore always finds space, so overflow is impossible by construction. Push and pop in the same cycle leave the count unchanged.
- Immediate decode is combinational on the FIFO head, using opcode = instr[6:0]:
  - 0110111 (LUI): `out_imm_sel`=01, `out_imm_raw`={16'b0, instr[31:16]}.
  - 0010011 (OP-IMM): `out_imm_sel`=00, `out_imm_raw`={20'b0, instr[31:20]}.
  - any other opcode: `out_imm_sel`=10, `out_imm_raw`=0.
- PC arithmetic is modulo 2^32; 32'hFFFF_FFFC + 4 wraps to 0.

## Timing
- Reset values: pc=RESET_PC, FSM in IDLE, FIFO empty. Outputs: `imem_req`=0, `imem_addr`=0, `out_valid`=0, `out_instr`=0, `out_pc`=0, `out_imm_sel`=10, `out_imm_raw`=0.
- First request is issued in the first cycle after `rst` deasserts.
- Output timing:
  - `out_valid` rises the cycle after the ack cycle (registered FIFO).
  - Minimum latency from request to `out_valid` is 2 cycles.
  - Peak throughput is 1 instruction per 2 cycles.
- Reset mid-transaction: the instruction memory shares `rst`, so no ack from before reset is ever delivered after reset.
- `imem_addr` is registered and is held at the last request value between requests.

## Structure
- Shared package `fetch_pkg` holds:
  - opcode constants OPC_LUI and OPC_OPIMM;
  - the `out_imm_sel` encodings IMM_LO, IMM_HI and IMM_NONE;
  - the FSM state encoding (IDLE, WAIT, DISCARD).
- Sub-module `fetch_fifo`: a synchronous FIFO parameterised by DEPTH and WIDTH=64. It has push, pop and flush inputs and count/valid outputs. flush has priority over push.

## Test plan
- Reset release, memory acks 1 cycle after each request, `out_ready`=1 → requests at addresses 0, 4, 8 and so on. The first `out_valid` appears 2 cycles after the first request, with `out_pc`=0.
- `out_ready`=0 held → exactly DEPTH=2 entries are fetched, after which `imem_req` stays 0. Raising `out_ready` resumes fetch at 8.
- Redirect to 32'h100 while in WAIT; the stale ack arrives 3 cycles later → the stale data is never presented. The next request goes to 32'h100.
- Redirect and ack in the same cycle → the acked data is dropped and the next request goes to `redirect_pc`, with no DISCARD cycle.
- Head instr 32'h12345_0B7 (LUI) → `out_imm_sel`=01, `out_imm_raw`=32'h0000_1234. Head 32'hFFF0_0093 (ADDI) → sel 00, raw 32'h0000_0FFF. Head 32'h0000_0033 → sel 10, raw 0.
- RESET_PC=32'hFFFF_FFF8 → requests at FFFF_FFF8, FFFF_FFFC, then 0000_0000 (wrap).

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared opcodes, immediate-select encodings, FSM states and the immediate
// pre-decode helper for the instruction fetch stage.
package fetch_pkg;

    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;

    localparam logic [1:0] IMM_LO   = 2'b00;
    localparam logic [1:0] IMM_HI   = 2'b01;
    localparam logic [1:0] IMM_NONE = 2'b10;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        DISCARD = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [1:0]  sel;
        logic [31:0] raw;
    } imm_dec_t;

    function automatic imm_dec_t decode_imm(input logic [31:0] instr);
        imm_dec_t d;
        d.sel = IMM_NONE;
        d.raw = '0;
        case (instr[6:0])
            OPC_LUI: begin
                d.sel = IMM_HI;
                d.raw = {16'b0, instr[31:16]};
            end
            OPC_OPIMM: begin
                d.sel = IMM_LO;
                d.raw = {20'b0, instr[31:20]};
            end
            default: ;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO holding {instr, pc} words; flush wins over push, and the head
// reads as zero while empty so decode sees a quiet bus.
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [WIDTH-1:0] head_data,
    output logic [CNT_W-1:0] count,
    output logic             valid
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        do_pop   = pop && (count_q != '0);
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = ptr_inc(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            if (push && !do_pop) begin
                count_d = count_q + CNT_W'(1);
            end else if (!push && do_pop) begin
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    assign valid     = (count_q != '0);
    assign count     = count_q;
    assign head_data = valid ? mem_q[rd_ptr_q] : '0;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: one outstanding imem request, prefetch FIFO, and
// immediate pre-decode of the FIFO head for the downstream immediate mux.
//
//   state   | meaning
//   IDLE    | free to issue a request when the FIFO has room
//   WAIT    | request outstanding, its ack will be pushed
//   DISCARD | request outstanding but redirected, its ack is dropped
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic [1:0]  out_imm_sel,
    output logic [31:0] out_imm_raw
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    fetch_state_e     state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic [31:0]      addr_q, addr_d;
    logic             issue;
    logic             push;
    logic             pop;
    logic             flush;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_valid;
    logic [63:0]      head_data;
    imm_dec_t         dec;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        addr_d  = addr_q;
        issue   = 1'b0;
        push    = 1'b0;
        flush   = 1'b0;
        if (redirect) begin
            pc_d  = redirect_pc;
            flush = 1'b1;
        end
        case (state_q)
            IDLE: begin
                if (!redirect && (fifo_count < CNT_W'(DEPTH))) begin
                    issue   = 1'b1;
                    addr_d  = pc_q;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (redirect) begin
                    state_d = imem_ack ? IDLE : DISCARD;
                end else if (imem_ack) begin
                    push    = 1'b1;
                    pc_d    = pc_q + 32'd4;
                    state_d = IDLE;
                end
            end
            DISCARD: begin
                if (imem_ack) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
        end
    end

    // Request is combinational off IDLE so back-to-back fetches take 2 cycles.
    assign imem_req  = issue && !rst;
    assign imem_addr = imem_req ? pc_q : addr_q;
    assign pop       = fifo_valid && out_ready;

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (64)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data ({imem_rdata, pc_q}),
        .pop       (pop),
        .flush     (flush),
        .head_data (head_data),
        .count     (fifo_count),
        .valid     (fifo_valid)
    );

    assign out_valid   = fifo_valid;
    assign out_instr   = head_data[63:32];
    assign out_pc      = head_data[31:0];
    assign dec         = decode_imm(out_instr);
    assign out_imm_sel = dec.sel;
    assign out_imm_raw = dec.raw;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a small instruction-memory model, a pop
// monitor, hand-built sequences and a table of immediate-decode vectors.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [1:0]  out_imm_sel;
    logic [31:0] out_imm_raw;

    logic        w_req;
    logic [31:0] w_addr;
    logic        w_ack;
    logic [31:0] w_rdata;
    logic        w_redirect = 1'b0;
    logic [31:0] w_redirect_pc = 32'h0;
    logic        w_valid;
    logic        w_ready = 1'b1;
    logic [31:0] w_instr;
    logic [31:0] w_pc;
    logic [1:0]  w_sel;
    logic [31:0] w_raw;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    int          ack_lat = 1;
    bit          use_override = 1'b0;
    logic [31:0] override_word = 32'h0;
    bit          pend = 1'b0;
    bit          w_pend = 1'b0;
    int          pend_cnt = 0;
    logic [31:0] pend_addr = 32'h0;

    logic [31:0] req_addrs[$];
    int          req_cyc[$];
    logic [31:0] w_addrs[$];
    logic [31:0] pop_pc[$];
    logic [31:0] pop_instr[$];
    int          pop_cyc[$];

    typedef struct {
        logic [31:0] instr;
        logic [1:0]  sel;
        logic [31:0] raw;
    } imm_vec_t;
    imm_vec_t vecs[6];

    fetch_unit dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_instr   (out_instr),
        .out_pc      (out_pc),
        .out_imm_sel (out_imm_sel),
        .out_imm_raw (out_imm_raw)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) dut_w (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (w_req),
        .imem_addr   (w_addr),
        .imem_ack    (w_ack),
        .imem_rdata  (w_rdata),
        .redirect    (w_redirect),
        .redirect_pc (w_redirect_pc),
        .out_valid   (w_valid),
        .out_ready   (w_ready),
        .out_instr   (w_instr),
        .out_pc      (w_pc),
        .out_imm_sel (w_sel),
        .out_imm_raw (w_raw)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] word_for(input logic [31:0] a);
        return use_override ? override_word : (a ^ 32'hC0DE_0000);
    endfunction

    // Memory model: ack arrives ack_lat cycles after the request cycle.
    initial begin
        imem_ack   = 1'b0;
        imem_rdata = 32'h0;
        w_ack      = 1'b0;
        w_rdata    = 32'h0000_0013;
        forever begin
            @(posedge clk);
            #1;
            imem_ack   = 1'b0;
            imem_rdata = 32'h0;
            w_ack      = 1'b0;
            if (pend) begin
                pend_cnt--;
                if (pend_cnt == 0) begin
                    pend       = 1'b0;
                    imem_ack   = 1'b1;
                    imem_rdata = word_for(pend_addr);
                end
            end
            if (w_pend) begin
                w_pend = 1'b0;
                w_ack  = 1'b1;
            end
            @(negedge clk);
            if (rst) begin
                pend   = 1'b0;
                w_pend = 1'b0;
            end else begin
                if (imem_req) begin
                    pend      = 1'b1;
                    pend_cnt  = ack_lat;
                    pend_addr = imem_addr;
                    req_addrs.push_back(imem_addr);
                    req_cyc.push_back(cyc);
                end
                if (w_req) begin
                    w_pend = 1'b1;
                    w_addrs.push_back(w_addr);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            pop_pc.push_back(out_pc);
            pop_instr.push_back(out_instr);
            pop_cyc.push_back(cyc);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_logs();
        req_addrs.delete();
        req_cyc.delete();
        w_addrs.delete();
        pop_pc.delete();
        pop_instr.delete();
        pop_cyc.delete();
    endtask

    task automatic apply_reset();
        rst      = 1'b1;
        redirect = 1'b0;
        tick(2);
        clear_logs();
        rst = 1'b0;
    endtask

    task automatic wait_req(input int n, input string name);
        int k = 0;
        while (req_addrs.size() < n && k < 50) begin
            tick();
            k++;
        end
        check(name, 32'(req_addrs.size() >= n), 32'd1);
    endtask

    function automatic int count_pc(input logic [31:0] pc);
        int c = 0;
        foreach (pop_pc[i]) if (pop_pc[i] == pc) c++;
        return c;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int rel_cyc;
        int k;

        vecs[0] = '{32'h1234_50B7, 2'b01, 32'h0000_1234};
        vecs[1] = '{32'hFFF0_0093, 2'b00, 32'h0000_0FFF};
        vecs[2] = '{32'h0000_0033, 2'b10, 32'h0000_0000};
        vecs[3] = '{32'hABCD_E037, 2'b01, 32'h0000_ABCD};
        vecs[4] = '{32'h7FF0_0013, 2'b00, 32'h0000_07FF};
        vecs[5] = '{32'hFFFF_F017, 2'b10, 32'h0000_0000};

        // Reset values, then streaming fetch with 1-cycle memory.
        ack_lat   = 1;
        out_ready = 1'b1;
        rst       = 1'b1;
        tick(2);
        check("rst_req",   {31'b0, imem_req},  32'h0);
        check("rst_addr",  imem_addr,          32'h0);
        check("rst_valid", {31'b0, out_valid}, 32'h0);
        check("rst_instr", out_instr,          32'h0);
        check("rst_pc",    out_pc,             32'h0);
        check("rst_sel",   {30'b0, out_imm_sel}, 32'h2);
        check("rst_raw",   out_imm_raw,        32'h0);
        clear_logs();
        rst     = 1'b0;
        rel_cyc = cyc;
        tick(12);
        check("t1_nreq",     32'(req_addrs.size() >= 4), 32'd1);
        check("t1_first_cyc", 32'(req_cyc[0] - rel_cyc), 32'd0);
        check("t1_addr0",    req_addrs[0], 32'h0);
        check("t1_addr1",    req_addrs[1], 32'h4);
        check("t1_addr2",    req_addrs[2], 32'h8);
        check("t1_addr3",    req_addrs[3], 32'hC);
        check("t1_req_gap",  32'(req_cyc[1] - req_cyc[0]), 32'd2);
        check("t1_npop",     32'(pop_pc.size() >= 2), 32'd1);
        check("t1_lat",      32'(pop_cyc[0] - req_cyc[0]), 32'd2);
        check("t1_pop_pc0",  pop_pc[0], 32'h0);
        check("t1_pop_ins0", pop_instr[0], word_for(32'h0));
        check("t1_pop_pc1",  pop_pc[1], 32'h4);
        check("wrap_nreq",   32'(w_addrs.size() >= 3), 32'd1);
        check("wrap_addr0",  w_addrs[0], 32'hFFFF_FFF8);
        check("wrap_addr1",  w_addrs[1], 32'hFFFF_FFFC);
        check("wrap_addr2",  w_addrs[2], 32'h0000_0000);

        // Back-pressure: only DEPTH fetches, then resume at 8.
        out_ready = 1'b0;
        apply_reset();
        tick(20);
        check("t2_nreq",     32'(req_addrs.size()), 32'd2);
        check("t2_addr1",    req_addrs[1], 32'h4);
        check("t2_req_idle", {31'b0, imem_req}, 32'h0);
        check("t2_addr_hold", imem_addr, 32'h4);
        check("t2_valid",    {31'b0, out_valid}, 32'h1);
        check("t2_head_pc",  out_pc, 32'h0);
        out_ready = 1'b1;
        tick(6);
        check("t2_nreq2",    32'(req_addrs.size() >= 3), 32'd1);
        check("t2_resume",   req_addrs[2], 32'h8);
        check("t2_pop_pc0",  pop_pc[0], 32'h0);
        check("t2_pop_pc1",  pop_pc[1], 32'h4);

        // Redirect in WAIT; stale ack 3 cycles after the redirect.
        ack_lat = 4;
        apply_reset();
        wait_req(1, "t3_wait_req");
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0100;
        tick();
        redirect = 1'b0;
        tick(20);
        check("t3_nreq",     32'(req_addrs.size() >= 2), 32'd1);
        check("t3_addr1",    req_addrs[1], 32'h100);
        check("t3_discard_gap", 32'(req_cyc[1] - req_cyc[0]), 32'd5);
        check("t3_npop",     32'(pop_pc.size() >= 1), 32'd1);
        check("t3_pop_pc0",  pop_pc[0], 32'h100);
        check("t3_pop_ins0", pop_instr[0], word_for(32'h100));
        check("t3_no_stale", 32'(count_pc(32'h0)), 32'd0);

        // Redirect coinciding with the ack: no DISCARD cycle.
        ack_lat = 1;
        apply_reset();
        wait_req(1, "t4_wait_req");
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0200;
        tick();
        redirect = 1'b0;
        tick(10);
        check("t4_nreq",     32'(req_addrs.size() >= 2), 32'd1);
        check("t4_addr1",    req_addrs[1], 32'h200);
        check("t4_gap",      32'(req_cyc[1] - req_cyc[0]), 32'd2);
        check("t4_npop",     32'(pop_pc.size() >= 1), 32'd1);
        check("t4_pop_pc0",  pop_pc[0], 32'h200);
        check("t4_no_stale", 32'(count_pc(32'h0)), 32'd0);

        // Immediate pre-decode on the FIFO head.
        use_override = 1'b1;
        out_ready    = 1'b0;
        foreach (vecs[i]) begin
            override_word = vecs[i].instr;
            apply_reset();
            k = 0;
            while (!out_valid && k < 20) begin
                tick();
                k++;
            end
            check($sformatf("imm%0d_valid", i), {31'b0, out_valid}, 32'h1);
            check($sformatf("imm%0d_instr", i), out_instr, vecs[i].instr);
            check($sformatf("imm%0d_sel", i),   {30'b0, out_imm_sel}, {30'b0, vecs[i].sel});
            check($sformatf("imm%0d_raw", i),   out_imm_raw, vecs[i].raw);
        end
        use_override = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
